// File: rtl/vga_timing_pkg.sv
// Timing-set constants for the VGA raster generator and a counter-width helper.
package vga_timing_pkg;

    // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam bit          VGA640_HS_POL   = 1'b0;
    localparam bit          VGA640_VS_POL   = 1'b0;

    // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs
    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FP     = 40;
    localparam int unsigned SVGA800_H_SYNC   = 128;
    localparam int unsigned SVGA800_H_BP     = 88;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FP     = 1;
    localparam int unsigned SVGA800_V_SYNC   = 4;
    localparam int unsigned SVGA800_V_BP     = 23;
    localparam bit          SVGA800_HS_POL   = 1'b1;
    localparam bit          SVGA800_VS_POL   = 1'b1;

    // 320x240 reduced test mode
    localparam int unsigned TEST320_H_ACTIVE = 320;
    localparam int unsigned TEST320_H_FP     = 8;
    localparam int unsigned TEST320_H_SYNC   = 48;
    localparam int unsigned TEST320_H_BP     = 24;
    localparam int unsigned TEST320_V_ACTIVE = 240;
    localparam int unsigned TEST320_V_FP     = 5;
    localparam int unsigned TEST320_V_SYNC   = 1;
    localparam int unsigned TEST320_V_BP     = 16;
    localparam bit          TEST320_HS_POL   = 1'b0;
    localparam bit          TEST320_VS_POL   = 1'b0;

    // Minimum bit width able to hold 0..total-1
    function automatic int unsigned min_width(input int unsigned total);
        return (total <= 1) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX back to zero.
module wrap_counter #(
    parameter int unsigned MAX = 7,
    parameter int unsigned W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap_c
);

    // Terminal count reached on an enabled cycle
    assign wrap_c = en && (count == W'(MAX));

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap_c ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, decode and an aligned output register.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FP     = VGA640_H_FP,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BP     = VGA640_H_BP,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FP     = VGA640_V_FP,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BP     = VGA640_V_BP,
    parameter bit          HS_POL   = VGA640_HS_POL,
    parameter bit          VS_POL   = VGA640_VS_POL,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          display_on,
    output logic          vblank,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Reject coordinate widths too narrow for the raster
    if (XW < min_width(H_TOTAL)) begin : g_xw_check
        $error("vga_timing_gen: XW=%0d cannot hold H_TOTAL=%0d", XW, H_TOTAL);
    end
    if (YW < min_width(V_TOTAL)) begin : g_yw_check
        $error("vga_timing_gen: YW=%0d cannot hold V_TOTAL=%0d", YW, V_TOTAL);
    end

    logic [XW-1:0] hc;
    logic [YW-1:0] vc;
    logic          hc_wrap;
    logic          vc_wrap;
    logic          at_origin;

    wrap_counter #(.MAX(H_TOTAL - 1), .W(XW)) u_hc (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en),
        .count  (hc),
        .wrap_c (hc_wrap)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .W(YW)) u_vc (
        .clk    (clk),
        .rst    (rst),
        .en     (pix_en && hc_wrap),
        .count  (vc),
        .wrap_c (vc_wrap)
    );

    // Counters sit at (0,0) after reset and after the last pixel of a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            at_origin <= 1'b1;
        end else if (pix_en) begin
            at_origin <= vc_wrap;
        end
    end

    logic hs_act_c;
    logic vs_act_c;
    logic de_c;
    logic vb_c;

    // Decode the current counter position
    always_comb begin
        hs_act_c = 1'b0;
        vs_act_c = 1'b0;
        de_c     = 1'b0;
        vb_c     = 1'b0;
        hs_act_c = (32'(hc) >= HS_START) && (32'(hc) < HS_END);
        vs_act_c = (32'(vc) >= VS_START) && (32'(vc) < VS_END);
        de_c     = (32'(hc) < H_ACTIVE) && (32'(vc) < V_ACTIVE);
        vb_c     = (32'(vc) >= V_ACTIVE);
    end

    // Output register: all outputs describe the same sampled pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            display_on  <= 1'b0;
            vblank      <= 1'b0;
            h_sync      <= !HS_POL;
            v_sync      <= !VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            x           <= hc;
            y           <= vc;
            display_on  <= de_c;
            vblank      <= vb_c;
            h_sync      <= hs_act_c ? HS_POL : !HS_POL;
            v_sync      <= vs_act_c ? VS_POL : !VS_POL;
            line_start  <= (hc == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a reduced raster (14 x 7, active-high syncs).
module tb_vga_timing_gen;

    localparam int unsigned HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;   // 14
    localparam int unsigned VT = VA + VF + VS + VB;   // 7
    localparam int unsigned XW = 4;
    localparam int unsigned YW = 3;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          hs;
        logic          vs;
        logic          de;
        logic          vb;
        logic          ls;
        logic          fs;
    } outs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_en = 1'b0;
    logic          h_sync, v_sync, display_on, vblank, line_start, frame_start;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(XW), .YW(YW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .display_on  (display_on),
        .vblank      (vblank),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    outs_t exp_q[$];
    outs_t last_exp;
    int    mhc = 0, mvc = 0;

    // Timing/tally trackers driven from observed outputs
    int clk_cnt = 0;
    int last_fs = -1, last_ls = -1;
    int exp_fs_period = 0, exp_ls_period = 0;
    bit tally_valid = 1'b0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ls_cnt = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic outs_t reset_vals();
        outs_t r;
        r = '0;
        r.hs = 1'b0;
        r.vs = 1'b0;
        return r;
    endfunction

    // Reference decode of a raster position
    function automatic outs_t ref_pixel(input int h, input int v);
        outs_t r;
        r.x  = XW'(h);
        r.y  = YW'(v);
        r.hs = (h >= 10 && h <= 11);
        r.vs = (v == 5);
        r.de = (h < 8 && v < 4);
        r.vb = (v >= 4);
        r.ls = (h == 0);
        r.fs = (h == 0 && v == 0);
        return r;
    endfunction

    task automatic restart_trackers();
        last_fs = -1;
        last_ls = -1;
        tally_valid = 1'b0;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
    endtask

    task automatic step(input logic en, input logic r);
        outs_t e;
        outs_t got;
        pix_en = en;
        rst    = r;
        if (r) begin
            e   = reset_vals();
            mhc = 0;
            mvc = 0;
        end else if (en) begin
            e = ref_pixel(mhc, mvc);
            if (mhc == int'(HT) - 1) begin
                mhc = 0;
                mvc = (mvc == int'(VT) - 1) ? 0 : mvc + 1;
            end else begin
                mhc = mhc + 1;
            end
        end else begin
            e    = last_exp;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        last_exp = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clk_cnt++;
        got = exp_q.pop_front();
        check("x", int'(x), int'(got.x));
        check("y", int'(y), int'(got.y));
        check("h_sync", int'(h_sync), int'(got.hs));
        check("v_sync", int'(v_sync), int'(got.vs));
        check("display_on", int'(display_on), int'(got.de));
        check("vblank", int'(vblank), int'(got.vb));
        check("line_start", int'(line_start), int'(got.ls));
        check("frame_start", int'(frame_start), int'(got.fs));
        if (r) begin
            restart_trackers();
        end else begin
            if (frame_start) begin
                if (tally_valid) begin
                    check("frame_de_pixels", de_cnt, int'(HA * VA));
                    check("frame_hsync_pixels", hs_cnt, int'(HS * VT));
                    check("frame_vsync_pixels", vs_cnt, int'(VS * HT));
                    check("frame_line_starts", ls_cnt, int'(VT));
                end
                if (last_fs >= 0 && exp_fs_period > 0)
                    check("frame_start_period", clk_cnt - last_fs, exp_fs_period);
                last_fs = clk_cnt;
                tally_valid = 1'b1;
                de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0;
            end
            if (line_start) begin
                if (last_ls >= 0 && exp_ls_period > 0)
                    check("line_start_period", clk_cnt - last_ls, exp_ls_period);
                last_ls = clk_cnt;
            end
            if (en) begin
                de_cnt += int'(display_on);
                hs_cnt += int'(h_sync);
                vs_cnt += int'(v_sync);
                ls_cnt += int'(line_start);
            end
        end
    endtask

    initial begin
        last_exp = reset_vals();
        // Reset state, including rst winning over pix_en
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Continuous pixel enable for two-plus frames
        restart_trackers();
        exp_fs_period = int'(HT * VT);
        exp_ls_period = int'(HT);
        for (int i = 0; i < 2 * int'(HT * VT) + 3; i++) step(1'b1, 1'b0);

        // Enable on every other clock doubles the periods
        restart_trackers();
        exp_fs_period = 2 * int'(HT * VT);
        exp_ls_period = 2 * int'(HT);
        for (int i = 0; i < 2 * int'(HT * VT) + 3; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end

        // Mid-frame reset held three clocks with pix_en high
        exp_fs_period = 0;
        exp_ls_period = 0;
        for (int i = 0; i < int'(HT * VT) && !(mhc == 5 && mvc == 3); i++) step(1'b1, 1'b0);
        check("reached_reset_point", (mhc == 5 && mvc == 3) ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("post_reset_frame_start", int'(frame_start), 1);
        check("post_reset_display_on", int'(display_on), 1);

        // Random pixel strobe pattern
        for (int i = 0; i < 400; i++) step(1'($urandom_range(0, 1)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
